ifid_npc: RTL
=============

Name: ifid_npc

Overview:
- D-stage front end of the 5-stage MIPS pipeline.
- Holds the IF/ID pipeline register that captures the fetch stage's instruction and PC+8.
- Decodes branches and jumps in D using forwarded register operands, and drives the fetch stage's npc, br and pcen inputs.
- Has a single branch delay slot and no flush: the delay-slot instruction always executes.

Parameters:
- RESET_PC8, 32'h0000_3008: value loaded into pc8_d on reset; the reset PC 0x3000 plus 8.
- NOP_INSTR, 32'h0000_0000: value loaded into instr_d on reset (sll $0,$0,0).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- instr_f  in  32  instruction from the fetch stage.
- pc8_f  in  32  PC+8 of instr_f, from the fetch stage.
- stall  in  1  hazard-unit stall request; holds F and D.
- rs_val_d  in  32  forwarded GPR[rs] of instr_d.
- rt_val_d  in  32  forwarded GPR[rt] of instr_d.
- instr_d  out  32  registered D-stage instruction.
- pc8_d  out  32  registered D-stage PC+8.
- bd_d  out  1  1 when instr_d is in the delay slot of a branch or jump.
- npc  out  32  branch/jump target for the fetch stage.
- br  out  1  1 when a control transfer is taken; the fetch stage loads npc instead of PC+4.
- pcen  out  1  fetch-stage PC enable; equals ~stall.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high, sampled on the rising edge of clk.
- Reset values: instr_d=NOP_INSTR, pc8_d=RESET_PC8, bd_d=0. Combinational outputs follow from these: br=0, npc=don't-care, pcen=~stall.
- IF/ID register update, on each posedge:
  - If rst: load the reset values.
  - Else if stall: hold instr_d, pc8_d and bd_d.
  - Else: instr_d<=instr_f, pc8_d<=pc8_f, bd_d<=is_cti(instr_d).
- is_cti is the decode of the current instr_d. It is true for beq, bne, blez, bgtz, bltz, bgez, j, jal, jr and jalr, whether taken or not.
- pcen=~stall, purely combinational, with zero latency.
- Decode uses the fields op=[31:26], rs=[25:21], rt=[20:16], fn=[5:0], imm=[15:0] and idx=[25:0].
- Derived value: pc4_d = pc8_d - 4, which is the delay-slot address.
- Branch taken conditions (signed compares use 32-bit two's complement):
  - beq: rs_val_d == rt_val_d
  - bne: rs_val_d != rt_val_d
  - blez: rs_val_d <= 0
  - bgtz: rs_val_d > 0
  - bltz (REGIMM, rt=0): rs_val_d < 0
  - bgez (REGIMM, rt=1): rs_val_d >= 0
- Branch target: npc = pc4_d + (sign_extend(imm) << 2). Addition is mod 2^32 and wraps silently.
- Jump target for j and jal: npc = {pc4_d[31:28], idx, 2'b00}. br=1 unconditionally.
- Target for jr and jalr: npc = rs_val_d. br=1. No alignment check.
- All other instructions, and REGIMM with rt not in {0,1}: br=0.
- Timing: br and npc are combinational from instr_d and the operands, so the target is ready in the same cycle the branch sits in D.
  - The fetch stage then holds the delay slot, so the next posedge loads the target.
  - Latency is one delay slot and zero bubbles.
- Stall together with a taken branch: br and npc stay valid but pcen=0, so the PC holds. The hazard unit keeps stall high until the operands are correct. The branch resolves on the first cycle with stall=0.
- Stall and rst together: rst wins and the register resets.
- Reset mid-branch: the pending transfer is dropped. br=0 from the next cycle.
- bd_d is cleared on reset and is not updated while stalled.

Decomposition:
- Shared package mips_defs holds:
  - Opcodes: OP_SPECIAL=6'h00, OP_REGIMM=6'h01, OP_J=6'h02, OP_JAL=6'h03, OP_BEQ=6'h04, OP_BNE=6'h05, OP_BLEZ=6'h06, OP_BGTZ=6'h07.
  - Functs: FN_JR=6'h08, FN_JALR=6'h09.
  - REGIMM rt codes: RT_BLTZ=5'h00, RT_BGEZ=5'h01.
  - The reset constants RESET_PC8 and NOP_INSTR.
- One combinational sub-module, npc_calc, takes (instr_d, pc8_d, rs_val_d, rt_val_d) and returns (npc, br, is_cti).
- The top level keeps the IF/ID register and the bd_d flag.

Test Plan:
- Reset and fill: assert rst for 2 cycles, then instr_f=0x00000000, pc8_f=0x3008.
  - During reset: instr_d=0, pc8_d=0x3008, bd_d=0, br=0, pcen=1.
- Taken beq: load beq $1,$2,+3 (0x10220003) with pc8_d=0x3008 and rs_val_d=rt_val_d=5.
  - Expect br=1 and npc=0x3004+12=0x3010.
  - Next non-stalled cycle: bd_d=1.
- Not-taken, then negative offset: bne with equal operands gives br=0.
  - bgez with imm=0xFFFF, rs_val_d=0, pc8_d=0x3010 gives br=1, npc=0x3008.
- Jumps: jal idx=0x0C04 with pc8_d=0x3020 gives npc=0x00003010, br=1.
  - jr with rs_val_d=0x0000_3ABC gives npc=0x3ABC, br=1.
- Stall hold: taken beq in D with stall=1 for 3 cycles.
  - Throughout: pcen=0, instr_d and pc8_d unchanged, br=1 throughout.
  - After stall drops: one advance, and bd_d=1.
- Signed compares: rs_val_d=0x8000_0000.
  - blez: br=1. bgtz: br=0. bltz: br=1.
  - rs_val_d=0 with bgtz: br=0.

Source files
------------

// File: rtl/mips_defs.sv
// Shared MIPS decode constants for the D-stage front end.
package mips_defs;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_REGIMM  = 6'h01;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_BLEZ    = 6'h06;
    localparam logic [5:0] OP_BGTZ    = 6'h07;

    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_JALR = 6'h09;

    localparam logic [4:0] RT_BLTZ = 5'h00;
    localparam logic [4:0] RT_BGEZ = 5'h01;

    localparam logic [31:0] RESET_PC8 = 32'h0000_3008;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/ifid_npc_if.sv
// Fetch/hazard <-> D-stage signal bundle for ifid_npc.
interface ifid_npc_if;

    logic [31:0] instr_f;
    logic [31:0] pc8_f;
    logic        stall;
    logic [31:0] rs_val_d;
    logic [31:0] rt_val_d;
    logic [31:0] instr_d;
    logic [31:0] pc8_d;
    logic        bd_d;
    logic [31:0] npc;
    logic        br;
    logic        pcen;

    // Fetch stage, hazard unit and forwarding network drive the master side.
    modport master (
        output instr_f, pc8_f, stall, rs_val_d, rt_val_d,
        input  instr_d, pc8_d, bd_d, npc, br, pcen
    );

    modport slave (
        input  instr_f, pc8_f, stall, rs_val_d, rt_val_d,
        output instr_d, pc8_d, bd_d, npc, br, pcen
    );

endinterface

// File: rtl/npc_calc.sv
// Combinational branch/jump decode and target generation for the D-stage instruction.
module npc_calc
    import mips_defs::*;
(
    input  logic [31:0] instr_i,
    input  logic [31:0] pc8_i,
    input  logic [31:0] rs_val_i,
    input  logic [31:0] rt_val_i,
    output logic [31:0] npc_o,
    output logic        br_o,
    output logic        is_cti_o
);

    logic [5:0]  op;
    logic [4:0]  rt;
    logic [5:0]  fn;
    logic [15:0] imm;
    logic [25:0] idx;
    logic [31:0] pc4;
    logic [31:0] br_tgt;
    logic        rs_neg;
    logic        rs_zero;

    assign op      = instr_i[31:26];
    assign rt      = instr_i[20:16];
    assign fn      = instr_i[5:0];
    assign imm     = instr_i[15:0];
    assign idx     = instr_i[25:0];
    assign pc4     = pc8_i - 32'd4;
    assign br_tgt  = pc4 + {{14{imm[15]}}, imm, 2'b00};
    assign rs_neg  = rs_val_i[31];
    assign rs_zero = (rs_val_i == 32'd0);

    always_comb begin
        npc_o    = br_tgt;
        br_o     = 1'b0;
        is_cti_o = 1'b0;
        case (op)
            OP_SPECIAL: begin
                if (fn == FN_JR || fn == FN_JALR) begin
                    npc_o    = rs_val_i;
                    br_o     = 1'b1;
                    is_cti_o = 1'b1;
                end
            end
            OP_REGIMM: begin
                // Only rt=0/1 are branches; other REGIMM encodings fall through as non-CTI.
                if (rt == RT_BLTZ) begin
                    br_o     = rs_neg;
                    is_cti_o = 1'b1;
                end else if (rt == RT_BGEZ) begin
                    br_o     = ~rs_neg;
                    is_cti_o = 1'b1;
                end
            end
            OP_J, OP_JAL: begin
                npc_o    = {pc4[31:28], idx, 2'b00};
                br_o     = 1'b1;
                is_cti_o = 1'b1;
            end
            OP_BEQ: begin
                br_o     = (rs_val_i == rt_val_i);
                is_cti_o = 1'b1;
            end
            OP_BNE: begin
                br_o     = (rs_val_i != rt_val_i);
                is_cti_o = 1'b1;
            end
            OP_BLEZ: begin
                br_o     = rs_neg | rs_zero;
                is_cti_o = 1'b1;
            end
            OP_BGTZ: begin
                br_o     = ~rs_neg & ~rs_zero;
                is_cti_o = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/ifid_npc.sv
// D-stage front end: IF/ID pipeline register, delay-slot flag and next-PC steering.
module ifid_npc #(
    parameter logic [31:0] RESET_PC8 = mips_defs::RESET_PC8,
    parameter logic [31:0] NOP_INSTR = mips_defs::NOP_INSTR
) (
    input logic        clk,
    input logic        rst,
    ifid_npc_if.slave  bus
);

    logic [31:0] instr_d_q, instr_d_d;
    logic [31:0] pc8_d_q, pc8_d_d;
    logic        bd_d_q, bd_d_d;
    logic        is_cti;

    npc_calc u_npc_calc (
        .instr_i  (instr_d_q),
        .pc8_i    (pc8_d_q),
        .rs_val_i (bus.rs_val_d),
        .rt_val_i (bus.rt_val_d),
        .npc_o    (bus.npc),
        .br_o     (bus.br),
        .is_cti_o (is_cti)
    );

    always_comb begin
        instr_d_d = instr_d_q;
        pc8_d_d   = pc8_d_q;
        bd_d_d    = bd_d_q;
        if (!bus.stall) begin
            instr_d_d = bus.instr_f;
            pc8_d_d   = bus.pc8_f;
            // The instruction after any CTI is its delay slot, taken or not.
            bd_d_d    = is_cti;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            instr_d_q <= NOP_INSTR;
            pc8_d_q   <= RESET_PC8;
            bd_d_q    <= 1'b0;
        end else begin
            instr_d_q <= instr_d_d;
            pc8_d_q   <= pc8_d_d;
            bd_d_q    <= bd_d_d;
        end
    end

    assign bus.instr_d = instr_d_q;
    assign bus.pc8_d   = pc8_d_q;
    assign bus.bd_d    = bd_d_q;
    assign bus.pcen    = ~bus.stall;

endmodule
